// File: rtl/tcb_lib_sram_sub.sv
// rtl/tcb_lib_sram_sub.sv - TCB subordinate backed by byte-enabled on-chip memory
// Programmable wait states, fixed response delay, out-of-range error responses.
module tcb_lib_sram_sub #(
  parameter int ABW  = 32,
  parameter int DBW  = 32,
  parameter int SLW  = 8,
  parameter int DLY  = 1,
  parameter int SIZ  = 4096,
  parameter int WAIT = 0
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tcb_vld,
  output logic                 tcb_rdy,
  input  logic                 tcb_wen,
  input  logic [ABW-1:0]       tcb_adr,
  input  logic [DBW/SLW-1:0]   tcb_ben,
  input  logic [DBW-1:0]       tcb_wdt,
  output logic [DBW-1:0]       tcb_rdt,
  output logic                 tcb_err
);

  localparam int BEW  = DBW / SLW;
  localparam int MAW  = $clog2(SIZ);
  localparam int BAW  = $clog2(BEW);
  localparam int WRDS = SIZ / BEW;
  localparam int PW   = DBW + 3;
  localparam logic [ABW:0] SIZ_W = (ABW+1)'(SIZ);

  typedef enum logic [1:0] {ST_IDLE, ST_WAIT, ST_ACK} state_t;

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic       rdy_q, rdy_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (WAIT != 0 && tcb_vld) begin
          cnt_d   = 4'(WAIT - 1);
          state_d = (WAIT == 1) ? ST_ACK : ST_WAIT;
        end
      end
      ST_WAIT: begin
        // A manager that withdraws its request mid-wait forfeits the transfer.
        if (!tcb_vld) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - 4'd1;
          if (cnt_q == 4'd1) state_d = ST_ACK;
        end
      end
      ST_ACK:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
    rdy_d = (WAIT == 0) ? 1'b1 : (state_d == ST_ACK);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      rdy_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdy_q   <= rdy_d;
    end
  end

  assign tcb_rdy = rdy_q;

  logic                 xfer;
  logic                 oor;
  logic [MAW-BAW-1:0]   widx;
  logic [DBW-1:0]       rd_dat;
  logic [DBW-1:0]       mem_q [WRDS];

  assign xfer = tcb_vld & rdy_q & ~rst;
  assign oor  = {1'b0, tcb_adr} >= SIZ_W;
  assign widx = tcb_adr[MAW-1:BAW];

  always_ff @(posedge clk) begin
    if (xfer && tcb_wen && !oor) begin
      for (int i = 0; i < BEW; i++) begin
        if (tcb_ben[i]) mem_q[widx][i*SLW +: SLW] <= tcb_wdt[i*SLW +: SLW];
      end
    end
  end

  always_comb begin
    rd_dat = '0;
    for (int i = 0; i < BEW; i++) begin
      if (tcb_ben[i] && !oor) rd_dat[i*SLW +: SLW] = mem_q[widx][i*SLW +: SLW];
    end
  end

  // Each slot carries {valid, write, error, data}; the last slot is the response cycle.
  logic [PW-1:0]  stg_q [DLY];
  logic [PW-1:0]  stg_in;
  logic [PW-1:0]  tail;
  logic [DBW-1:0] rdt_q, rdt_d;

  assign stg_in = {xfer, tcb_wen, oor, rd_dat};
  assign tail   = stg_q[DLY-1];

  always_comb begin
    rdt_d = rdt_q;
    if (tail[PW-1] && (tail[PW-3] || !tail[PW-2])) rdt_d = tail[DBW-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DLY; i++) stg_q[i] <= '0;
      rdt_q <= '0;
    end else begin
      stg_q[0] <= stg_in;
      for (int i = 1; i < DLY; i++) stg_q[i] <= stg_q[i-1];
      rdt_q <= rdt_d;
    end
  end

  assign tcb_rdt = rdt_d;
  assign tcb_err = tail[PW-1] & tail[PW-3];

endmodule
